player_input_receiver: RTL and testbench
========================================

Name: player_input_receiver

Overview:
- Input-side front end for the two-player LED-matrix game.
- Takes the 12 raw, bouncy push-button/switch lines for both players (move, attack, defense), then synchronises and debounces them.
- Emits clean levels plus single-cycle press, release and auto-repeat pulses.
- The movement and skill logic consume these pulses instead of sampling raw buttons on slow divided clocks.

Parameters:
NUM_BTN, 12, number of button lines; bit map [0]a_up [1]a_down [2]a_left [3]a_right [4]a_attack [5]a_defense [6]b_up [7]b_down [8]b_left [9]b_right [10]b_attack [11]b_defense
TICK_DIV, 50000, CLK cycles per sample tick (1 ms at 50 MHz)
DEB_TICKS, 10, consecutive differing ticks required to accept a level change
RPT_DELAY, 300, ticks from press to first auto-repeat pulse
RPT_RATE, 100, ticks between subsequent auto-repeat pulses
REPEAT_MASK, 12'h3CF, 1 = auto-repeat enabled for that bit (movement keys)

Ports:
CLK  input  1  system clock
Clear  input  1  reset, asynchronous, active-high
btn_raw  input  NUM_BTN  raw button lines, asynchronous to CLK, active-high
enable  input  1  0 = suppress all pulses (game over); levels still tracked
btn_level  output  NUM_BTN  debounced level
btn_press  output  NUM_BTN  1-cycle pulse on debounced 0->1
btn_release  output  NUM_BTN  1-cycle pulse on debounced 1->0
btn_repeat  output  NUM_BTN  press pulse plus auto-repeat pulses (masked bits only)
any_press  output  1  OR of btn_press

Behaviour:
- One clock (CLK); reset is asynchronous and active-high (Clear). While Clear is high, every register and output is 0: sync flops, tick counter, debounce counters, repeat FSMs, and all outputs.
- Synchroniser: two flops per bit. `sync` is btn_raw delayed by 2 CLK cycles.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - `tick` is high for one cycle when the counter equals TICK_DIV-1.
  - The counter restarts from 0 after Clear.
- Debounce, per bit, evaluated only on tick cycles:
  - If sync != level: deb_cnt increments.
  - When deb_cnt == DEB_TICKS-1 at a tick: level toggles and deb_cnt clears to 0 on the same edge.
  - If sync == level at a tick: deb_cnt clears.
  - deb_cnt holds between ticks. Width is clog2(DEB_TICKS), and it never wraps.
- Edge pulses:
  - btn_press[i] / btn_release[i] are registered and high exactly in the first cycle btn_level[i] shows its new value.
  - Each pulse lasts one CLK cycle and is gated by enable.
- Repeat FSM, per bit with REPEAT_MASK=1, states IDLE / DELAY / REPEAT with counter rpt_cnt:
  - IDLE: on level 0->1, btn_repeat pulses in the same cycle as btn_press; go to DELAY with rpt_cnt=0.
  - DELAY: on each tick rpt_cnt++. At a tick where rpt_cnt == RPT_DELAY-1, pulse, go to REPEAT, rpt_cnt=0.
  - REPEAT: on each tick rpt_cnt++. At a tick where rpt_cnt == RPT_RATE-1, pulse, rpt_cnt=0.
  - Level 1->0 in any state: go to IDLE and clear rpt_cnt. No repeat pulse in that cycle.
  - The FSM advances while enable=0; only the outputs are gated.
  - For bits with REPEAT_MASK=0, btn_repeat[i] == btn_press[i].
- Simultaneous events: bits are fully independent, so multiple bits may pulse in the same cycle. A release and a repeat due on the same tick produce only the release.
- Clear mid-operation: state is dropped immediately. A button still held when Clear falls is treated as a new press after sync plus DEB_TICKS ticks.
- Latency from a clean raw edge to the level change: 2 cycles + between (DEB_TICKS-1)*TICK_DIV+1 and DEB_TICKS*TICK_DIV cycles.

Test Plan (TICK_DIV=4, DEB_TICKS=3, RPT_DELAY=5, RPT_RATE=2 unless stated):
1. Clear pulsed mid-run with buttons held -> all outputs 0 in the same cycle. After Clear falls, btn_level stays 0 for at least 10 cycles, then rises with exactly one btn_press.
2. Clean rise on btn_raw[0] -> btn_level[0]=1 between 11 and 14 cycles later, with exactly one btn_press[0] and one btn_repeat[0]. Clean fall later -> one btn_release[0] with the same latency bounds.
3. Bounce: btn_raw[4] toggles every 3 cycles for 48 cycles, then stays high -> no level change during the bounce. Afterwards exactly one btn_press[4] and no btn_release[4].
4. Hold btn_raw[0] for 39 ticks after the press cycle -> btn_repeat[0] pulses at ticks 0, 5, 7, 9 … 39, i.e. 19 pulses. After release, no further repeats.
5. Hold btn_raw[4] (unmasked) for 40 ticks -> exactly one btn_repeat[4], coincident with btn_press[4].
6. enable=0, press bits 1 and 7 together -> btn_level = 12'h082 and no pulses. Set enable=1 while held -> repeats resume on schedule, with no retroactive press pulse.

Source files
------------

// File: rtl/player_input_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : player_input_receiver
// Description : Synchronises and debounces both players' buttons; emits clean
//               levels plus press / release / auto-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module player_input_receiver #(
  parameter int                 NUM_BTN     = 12,
  parameter int                 TICK_DIV    = 50000,
  parameter int                 DEB_TICKS   = 10,
  parameter int                 RPT_DELAY   = 300,
  parameter int                 RPT_RATE    = 100,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK = 12'h3CF
) (
  input  logic               CLK,
  input  logic               Clear,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               enable,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic               any_press
);

  localparam int c_TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_DEB_W   = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int c_RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
  localparam int c_RPT_W   = (c_RPT_MAX > 1) ? $clog2(c_RPT_MAX) : 1;

  localparam logic [c_TICK_W-1:0] c_TICK_LAST  = c_TICK_W'(TICK_DIV - 1);
  localparam logic [c_DEB_W-1:0]  c_DEB_LAST   = c_DEB_W'(DEB_TICKS - 1);
  localparam logic [c_RPT_W-1:0]  c_DELAY_LAST = c_RPT_W'(RPT_DELAY - 1);
  localparam logic [c_RPT_W-1:0]  c_RATE_LAST  = c_RPT_W'(RPT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [NUM_BTN-1:0]  r_sync1;
  logic [NUM_BTN-1:0]  r_sync2;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                w_tick;

  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_bit
      logic [c_DEB_W-1:0] r_deb_cnt;
      logic               r_lvl;
      logic               r_press;
      logic               r_release;
      logic               w_flip;
      logic               w_rise;
      logic               w_fall;

      // A level flip happens on the tick that completes the debounce run.
      assign w_flip = w_tick && (r_sync2[gi] != r_lvl) && (r_deb_cnt == c_DEB_LAST);
      assign w_rise = w_flip && !r_lvl;
      assign w_fall = w_flip && r_lvl;

      always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
          r_deb_cnt <= '0;
          r_lvl     <= 1'b0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= w_rise && enable;
          r_release <= w_fall && enable;
          if (w_flip) begin
            r_lvl     <= ~r_lvl;
            r_deb_cnt <= '0;
          end else if (w_tick) begin
            if (r_sync2[gi] != r_lvl) begin
              r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
            end else begin
              r_deb_cnt <= '0;
            end
          end
        end
      end

      assign btn_level[gi]   = r_lvl;
      assign btn_press[gi]   = r_press;
      assign btn_release[gi] = r_release;

      if (REPEAT_MASK[gi]) begin : g_rpt
        rpt_state_t         r_state;
        rpt_state_t         w_state_nxt;
        logic [c_RPT_W-1:0] r_rpt_cnt;
        logic [c_RPT_W-1:0] w_rpt_cnt_nxt;
        logic               w_rpt_pulse;
        logic               r_repeat;

        always_ff @(posedge CLK or posedge Clear) begin
          if (Clear) begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
          end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_repeat  <= w_rpt_pulse && enable;
          end
        end

        // Release has priority so a release tick never also repeats.
        always_comb begin
          w_state_nxt   = r_state;
          w_rpt_cnt_nxt = r_rpt_cnt;
          w_rpt_pulse   = 1'b0;
          if (w_fall) begin
            w_state_nxt   = ST_IDLE;
            w_rpt_cnt_nxt = '0;
          end else if (w_rise) begin
            w_rpt_pulse   = 1'b1;
            w_state_nxt   = ST_DELAY;
            w_rpt_cnt_nxt = '0;
          end else begin
            case (r_state)
              ST_DELAY: begin
                if (w_tick) begin
                  if (r_rpt_cnt == c_DELAY_LAST) begin
                    w_rpt_pulse   = 1'b1;
                    w_state_nxt   = ST_REPEAT;
                    w_rpt_cnt_nxt = '0;
                  end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + c_RPT_W'(1);
                  end
                end
              end
              ST_REPEAT: begin
                if (w_tick) begin
                  if (r_rpt_cnt == c_RATE_LAST) begin
                    w_rpt_pulse   = 1'b1;
                    w_rpt_cnt_nxt = '0;
                  end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + c_RPT_W'(1);
                  end
                end
              end
              default: begin
                w_state_nxt   = ST_IDLE;
                w_rpt_cnt_nxt = '0;
              end
            endcase
          end
        end

        assign btn_repeat[gi] = r_repeat;
      end else begin : g_norpt
        assign btn_repeat[gi] = r_press;
      end
    end
  endgenerate

  assign any_press = |btn_press;

endmodule
`default_nettype wire

// File: tb/tb_player_input_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for player_input_receiver with a short tick and small
// debounce / repeat constants so every scenario fits in a few hundred cycles.
module tb_player_input_receiver;
  localparam int NB = 12;

  logic          CLK = 1'b0;
  logic          Clear;
  logic          enable;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_repeat;
  logic          any_press;

  always #5 CLK = ~CLK;

  player_input_receiver #(
    .NUM_BTN     (NB),
    .TICK_DIV    (4),
    .DEB_TICKS   (3),
    .RPT_DELAY   (5),
    .RPT_RATE    (2),
    .REPEAT_MASK (12'h3CF)
  ) dut (
    .CLK         (CLK),
    .Clear       (Clear),
    .btn_raw     (btn_raw),
    .enable      (enable),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .any_press   (any_press)
  );

  int n_total = 0;
  int n_bad   = 0;

  int n_press [NB] = '{default: 0};
  int n_rel   [NB] = '{default: 0};
  int n_rpt   [NB] = '{default: 0};
  int n_lvl_chg [NB] = '{default: 0};
  int n_anyp   = 0;
  int n_relrpt = 0;
  int n_pulse  = 0;
  int n_both4  = 0;
  logic [NB-1:0] prev_level = '0;

  // Running event counters; the main thread compares snapshots of these.
  always @(negedge CLK) begin
    n_pulse <= n_pulse + $countones(btn_press) + $countones(btn_release) + $countones(btn_repeat);
    if (any_press) n_anyp <= n_anyp + 1;
    if (|(btn_release & btn_repeat)) n_relrpt <= n_relrpt + 1;
    if (btn_press[4] && btn_repeat[4]) n_both4 <= n_both4 + 1;
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i])   n_press[i] <= n_press[i] + 1;
      if (btn_release[i]) n_rel[i]   <= n_rel[i] + 1;
      if (btn_repeat[i])  n_rpt[i]   <= n_rpt[i] + 1;
      if (btn_level[i] != prev_level[i]) n_lvl_chg[i] <= n_lvl_chg[i] + 1;
    end
    prev_level <= btn_level;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_raw(input logic [NB-1:0] v);
    @(posedge CLK);
    #1;
    btn_raw = v;
  endtask

  task automatic wait_level(input int b, input logic v, input int lim, output int n);
    n = 0;
    while (btn_level[b] !== v && n < lim) begin
      @(negedge CLK);
      n++;
    end
  endtask

  int lat, s_a, s_b, s_c, s_d, s_e, cnt, cnt7, badpos;

  initial begin
    Clear   = 1'b1;
    enable  = 1'b1;
    btn_raw = '0;
    wait_neg(3);
    check_val("rst_level",   btn_level,   0);
    check_val("rst_press",   btn_press,   0);
    check_val("rst_release", btn_release, 0);
    check_val("rst_repeat",  btn_repeat,  0);
    check_val("rst_any",     any_press,   0);
    @(posedge CLK);
    #1;
    Clear = 1'b0;
    wait_neg(4);

    // Clean press and release of a movement key
    s_a = n_press[0]; s_b = n_rpt[0]; s_c = n_rel[0];
    drive_raw(12'h001);
    wait_level(0, 1'b1, 40, lat);
    check_val($sformatf("t2_rise_lat=%0d_in_11_14", lat), (lat >= 11 && lat <= 14), 1);
    wait_neg(2);
    check_val("t2_press_cnt",  n_press[0] - s_a, 1);
    check_val("t2_repeat_cnt", n_rpt[0] - s_b, 1);
    drive_raw(12'h000);
    wait_level(0, 1'b0, 40, lat);
    check_val($sformatf("t2_fall_lat=%0d_in_11_14", lat), (lat >= 11 && lat <= 14), 1);
    wait_neg(2);
    check_val("t2_release_cnt", n_rel[0] - s_c, 1);
    check_val("t2_repeat_after", n_rpt[0] - s_b, 1);

    // Bouncing attack key, then a steady hold
    s_a = n_lvl_chg[4]; s_b = n_press[4]; s_c = n_rel[4]; s_d = n_rpt[4]; s_e = n_both4;
    @(posedge CLK);
    #1;
    for (int s = 0; s < 16; s++) begin
      btn_raw[4] = (s % 2 == 0);
      repeat (3) @(posedge CLK);
      #1;
    end
    btn_raw[4] = 1'b1;
    wait_neg(2);
    check_val("t3_bounce_lvl_chg", n_lvl_chg[4] - s_a, 0);
    wait_level(4, 1'b1, 40, lat);
    check_val("t3_level_up", btn_level[4], 1);
    wait_neg(160);
    check_val("t3_press_cnt",   n_press[4] - s_b, 1);
    check_val("t3_release_cnt", n_rel[4] - s_c, 0);
    check_val("t5_repeat_cnt",  n_rpt[4] - s_d, 1);
    check_val("t5_press_eq_rpt", n_both4 - s_e, 1);
    drive_raw(12'h000);
    wait_level(4, 1'b0, 40, lat);
    check_val("t5_level_down", btn_level[4], 0);
    wait_neg(4);

    // Long hold on a repeating key: pulses at ticks 0,5,7,...,39
    drive_raw(12'h001);
    lat = 0;
    while (!btn_press[0] && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check_val("t4_press_seen", btn_press[0], 1);
    cnt = 0; badpos = 0;
    for (int j = 0; j <= 156; j++) begin
      if (j > 0) @(negedge CLK);
      if (btn_repeat[0]) begin
        cnt++;
        if (!(j % 4 == 0 && (j == 0 || (j / 4 >= 5 && (j / 4) % 2 == 1)))) badpos++;
      end
    end
    check_val("t4_repeat_cnt", cnt, 19);
    check_val("t4_repeat_pos_bad", badpos, 0);
    drive_raw(12'h000);
    wait_level(0, 1'b0, 40, lat);
    wait_neg(2);
    s_a = n_rpt[0];
    wait_neg(40);
    check_val("t4_rpt_after_release", n_rpt[0] - s_a, 0);

    // Game-over suppression, then resume while still held
    enable = 1'b0;
    s_a = n_press[1]; s_b = n_press[7];
    drive_raw(12'h082);
    lat = 0;
    while (btn_level !== 12'h082 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check_val("t6_level", btn_level, 12'h082);
    s_c = n_pulse;
    cnt = 0; cnt7 = 0; badpos = 0;
    for (int j = 0; j <= 40; j++) begin
      if (j > 0) @(negedge CLK);
      if (j == 8) begin
        check_val("t6_pulses_disabled", n_pulse - s_c, 0);
        enable = 1'b1;
      end
      if (btn_repeat[1]) begin
        cnt++;
        if (!(j == 20 || j == 28 || j == 36)) badpos++;
      end
      if (btn_repeat[7]) begin
        cnt7++;
        if (!(j == 20 || j == 28 || j == 36)) badpos++;
      end
    end
    check_val("t6_rpt1_cnt", cnt, 3);
    check_val("t6_rpt7_cnt", cnt7, 3);
    check_val("t6_rpt_pos_bad", badpos, 0);
    check_val("t6_no_retro_press", (n_press[1] - s_a) + (n_press[7] - s_b), 0);

    // Clear while buttons 1 and 7 are held
    @(posedge CLK);
    #2;
    Clear = 1'b1;
    @(negedge CLK);
    check_val("t1_clr_level",   btn_level,   0);
    check_val("t1_clr_press",   btn_press,   0);
    check_val("t1_clr_release", btn_release, 0);
    check_val("t1_clr_repeat",  btn_repeat,  0);
    check_val("t1_clr_any",     any_press,   0);
    wait_neg(2);
    @(posedge CLK);
    #1;
    Clear = 1'b0;
    s_a = n_press[1]; s_b = n_anyp;
    lat = 0;
    while (btn_level !== 12'h082 && lat < 60) begin
      @(negedge CLK);
      lat++;
    end
    check_val("t1_relevel", btn_level, 12'h082);
    check_val($sformatf("t1_relevel_lat=%0d_ge_10", lat), (lat >= 10), 1);
    wait_neg(3);
    check_val("t1_press_cnt", n_press[1] - s_a, 1);
    check_val("t1_any_cnt",   n_anyp - s_b, 1);

    check_val("rel_rpt_overlap", n_relrpt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
